// File: rtl/state_pkg.sv
// Shared types and default constants for the player motion controller.
package state_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2
  } State;

  typedef enum logic [1:0] {
    V_GROUND = 2'd0,
    V_RISE   = 2'd1,
    V_FALL   = 2'd2
  } VState;

  localparam int unsigned SCREEN_W_DEF = 1024;
  localparam int unsigned Y_GROUND_DEF = 500;

endpackage

// File: rtl/tick_rise_detect.sv
// Rising-edge detector for the frame tick; history resets high so a tick
// already asserted when reset releases does not count as an edge.
module tick_rise_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  output logic rise_o
);

  logic tick_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tick_q <= 1'b1;
    else         tick_q <= tick_i;
  end

  assign rise_o = tick_i & ~tick_q;

endmodule

// File: rtl/player_motion_ctl.sv
// Per-frame player movement with screen limits, a button-controlled gate and
// configurable step. Define PLAYER_JUMP_EN to add the jump port and vertical FSM.
module player_motion_ctl
  import state_pkg::*;
#(
  parameter int unsigned POS_W       = 12,
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = SCREEN_W_DEF - 1,
  parameter int unsigned X_START     = 0,
  parameter int unsigned STEP        = 1,
  parameter int unsigned GATE_LO     = 300,
  parameter int unsigned GATE_HI     = 400,
  parameter int unsigned Y_GROUND    = Y_GROUND_DEF,
  parameter int unsigned JUMP_HEIGHT = 64,
  parameter int unsigned STEP_Y      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_tick,
  input  logic             m_left,
  input  logic             m_right,
  input  logic             button_pressed,
`ifdef PLAYER_JUMP_EN
  input  logic             jump,
`endif
  output logic [POS_W-1:0] xpos_player,
  output logic [POS_W-1:0] ypos_player,
  output State             player_state
);

  // One extra bit keeps x+STEP from wrapping before the limit compare.
  localparam int unsigned EW = POS_W + 1;
  typedef logic [EW-1:0] ext_t;

  localparam ext_t XMIN_E = ext_t'(X_MIN);
  localparam ext_t XMAX_E = ext_t'(X_MAX);
  localparam ext_t STEP_E = ext_t'(STEP);
  localparam ext_t GLO_E  = ext_t'(GATE_LO);
  localparam ext_t GHI_E  = ext_t'(GATE_HI);

  logic frame_evt;

  tick_rise_detect u_tick (
    .clk_i  (clk),
    .rst_ni (rst),
    .tick_i (v_tick),
    .rise_o (frame_evt)
  );

  State             state_q, state_d;
  logic [POS_W-1:0] x_q, x_d;
  ext_t             x_e, right_e, left_e, cand_e;

  always_comb begin
    state_d = IDLE;
    x_e     = {1'b0, x_q};
    right_e = x_e + STEP_E;
    if (right_e > XMAX_E) right_e = XMAX_E;
    left_e  = (x_e < XMIN_E + STEP_E) ? XMIN_E : x_e - STEP_E;
    cand_e  = x_e;

    if (m_right && !m_left) begin
      state_d = RIGHT;
      cand_e  = right_e;
    end else if (m_left && !m_right) begin
      state_d = LEFT;
      cand_e  = left_e;
    end

    // Closed gate: frozen inside, and approaches snap onto the nearer edge.
    if (!button_pressed) begin
      if (x_e > GLO_E && x_e < GHI_E) begin
        cand_e = x_e;
      end else if (state_d == RIGHT && x_e <= GLO_E && cand_e > GLO_E) begin
        cand_e = GLO_E;
      end else if (state_d == LEFT && x_e >= GHI_E && cand_e < GHI_E) begin
        cand_e = GHI_E;
      end
    end

    x_d = POS_W'(cand_e);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= POS_W'(X_START);
      state_q <= IDLE;
    end else if (frame_evt) begin
      x_q     <= x_d;
      state_q <= state_d;
    end
  end

  assign xpos_player  = x_q;
  assign player_state = state_q;

`ifdef PLAYER_JUMP_EN
  localparam ext_t YGND_E = ext_t'(Y_GROUND);
  localparam ext_t YTOP_E = ext_t'(Y_GROUND - JUMP_HEIGHT);
  localparam ext_t STPY_E = ext_t'(STEP_Y);

  VState            v_q, v_d;
  logic [POS_W-1:0] y_q, y_d;
  logic [7:0]       rise_cnt_q, rise_cnt_d;
  ext_t             y_e, y_n;

  always_comb begin
    v_d        = v_q;
    rise_cnt_d = rise_cnt_q;
    y_e        = {1'b0, y_q};
    y_n        = y_e;

    case (v_q)
      V_GROUND: begin
        if (jump) begin
          v_d        = V_RISE;
          rise_cnt_d = 8'd0;
        end
      end
      V_RISE: begin
        y_n        = (y_e < YTOP_E + STPY_E) ? YTOP_E : y_e - STPY_E;
        rise_cnt_d = rise_cnt_q + 8'd1;
        if (y_n == YTOP_E) v_d = V_FALL;
      end
      V_FALL: begin
        y_n = (y_e + STPY_E >= YGND_E) ? YGND_E : y_e + STPY_E;
        if (y_n == YGND_E) v_d = V_GROUND;
      end
      default: v_d = V_GROUND;
    endcase

    y_d = POS_W'(y_n);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q        <= V_GROUND;
      y_q        <= POS_W'(Y_GROUND);
      rise_cnt_q <= 8'd0;
    end else if (frame_evt) begin
      v_q        <= v_d;
      y_q        <= y_d;
      rise_cnt_q <= rise_cnt_d;
    end
  end

  assign ypos_player = y_q;
`else
  assign ypos_player = POS_W'(Y_GROUND);
`endif

endmodule

// File: tb/tb_player_motion_ctl.sv
// Randomized bench for player_motion_ctl: two instances (STEP=1 and STEP=4)
// share stimulus and are compared each frame against a behavioural model.
module tb_player_motion_ctl;
  import state_pkg::*;

  localparam int GLO = 300;
  localparam int GHI = 400;
  localparam int XMN = 0;
  localparam int XMX = 1023;
  localparam int YG  = 500;
  localparam int YT  = 436;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_tick;
  logic        m_left, m_right, button_pressed;
  logic        jump;
  logic [11:0] xp1, yp1, xp4, yp4;
  State        st1, st4;

  int n_tests = 0;
  int n_fail  = 0;

  int x1_m, x4_m, st_m, y_m, vs_m;

  always #5 clk = ~clk;

  player_motion_ctl #(.STEP(1)) u_dut1 (
    .clk            (clk),
    .rst            (rst),
    .v_tick         (v_tick),
    .m_left         (m_left),
    .m_right        (m_right),
    .button_pressed (button_pressed),
`ifdef PLAYER_JUMP_EN
    .jump           (jump),
`endif
    .xpos_player    (xp1),
    .ypos_player    (yp1),
    .player_state   (st1)
  );

  player_motion_ctl #(.STEP(4)) u_dut4 (
    .clk            (clk),
    .rst            (rst),
    .v_tick         (v_tick),
    .m_left         (m_left),
    .m_right        (m_right),
    .button_pressed (button_pressed),
`ifdef PLAYER_JUMP_EN
    .jump           (jump),
`endif
    .xpos_player    (xp4),
    .ypos_player    (yp4),
    .player_state   (st4)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Spec-level horizontal rule in plain signed integer arithmetic.
  function automatic int model_x(int x, int dir, bit btn, int step);
    int nx = x;
    if (dir == 1) nx = (x + step > XMX) ? XMX : x + step;
    if (dir == 2) nx = (x - step < XMN) ? XMN : x - step;
    if (!btn) begin
      if (x > GLO && x < GHI)                      nx = x;
      else if (dir == 1 && x <= GLO && nx > GLO)   nx = GLO;
      else if (dir == 2 && x >= GHI && nx < GHI)   nx = GHI;
    end
    return nx;
  endfunction

  task automatic model_reset();
    x1_m = 0; x4_m = 0; st_m = int'(IDLE); y_m = YG; vs_m = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_x1"}, int'(xp1), x1_m);
    check({tag, "_x4"}, int'(xp4), x4_m);
    check({tag, "_st1"}, int'(st1), st_m);
    check({tag, "_st4"}, int'(st4), st_m);
    check({tag, "_y"}, int'(yp1), y_m);
  endtask

  task automatic frame(input bit l, input bit r, input bit b, input bit j);
    int dir;
    @(negedge clk);
    m_left = l; m_right = r; button_pressed = b; jump = j;
    v_tick = 1'b1;
    @(negedge clk);
    dir  = (r && !l) ? 1 : ((l && !r) ? 2 : 0);
    x1_m = model_x(x1_m, dir, b, 1);
    x4_m = model_x(x4_m, dir, b, 4);
    st_m = (dir == 1) ? int'(RIGHT) : ((dir == 2) ? int'(LEFT) : int'(IDLE));
`ifdef PLAYER_JUMP_EN
    if (vs_m == 0) begin
      if (j) vs_m = 1;
    end else if (vs_m == 1) begin
      y_m = (y_m - 4 < YT) ? YT : y_m - 4;
      if (y_m == YT) vs_m = 2;
    end else begin
      y_m = (y_m + 4 > YG) ? YG : y_m + 4;
      if (y_m == YG) vs_m = 0;
    end
`endif
    // Input noise while the tick stays high and while it is low must not move anything.
    repeat ($urandom_range(0, 3)) begin
      {m_left, m_right, button_pressed, jump} = 4'($urandom);
      @(negedge clk);
    end
    v_tick = 1'b0;
    repeat ($urandom_range(1, 2)) begin
      {m_left, m_right, button_pressed, jump} = 4'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic frames(input int n, input bit l, input bit r, input bit b, input string tag);
    for (int i = 0; i < n; i++) begin
      frame(l, r, b, 1'b0);
      check_all(tag);
    end
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all({tag, "_async"});
    v_tick = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all({tag, "_rel_high"});
    v_tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; v_tick = 1'b1;
    m_left = 1'b1; m_right = 1'b0; button_pressed = 1'b1; jump = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all("reset");
    check("reset_x_const", int'(xp1), 0);
    check("reset_y_const", int'(yp1), 500);
    v_tick = 1'b0;
    @(negedge clk);

    frames(10, 1'b0, 1'b1, 1'b0, "right10");
    check("right10_x", int'(xp1), 10);
    check("right10_st", int'(st1), int'(RIGHT));
    frames(1, 1'b1, 1'b1, 1'b0, "both");
    check("both_x", int'(xp1), 10);
    check("both_st", int'(st1), int'(IDLE));

    frames(70, 1'b0, 1'b1, 1'b0, "to_gate");
    check("snap_lo", int'(xp4), 300);
    frames(3, 1'b0, 1'b1, 1'b1, "open_gate");
    check("open_gate_x", int'(xp4), 312);
    frames(3, 1'b0, 1'b1, 1'b0, "in_gate_r");
    frames(3, 1'b1, 1'b0, 1'b0, "in_gate_l");
    check("in_gate_hold", int'(xp4), 312);
    frames(23, 1'b0, 1'b1, 1'b1, "past_gate");
    frames(3, 1'b1, 1'b0, 1'b0, "snap_hi");
    check("snap_hi_x", int'(xp4), 400);
    check("snap_hi_st", int'(st4), int'(LEFT));
    frames(160, 1'b0, 1'b1, 1'b1, "sat_r");
    check("sat_r_x", int'(xp4), 1023);
    frames(260, 1'b1, 1'b0, 1'b1, "sat_l");
    check("sat_l_x", int'(xp4), 0);

    for (int i = 0; i < 300; i++) begin
      frame(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
      check_all("rand");
    end

    async_reset("mid");

`ifdef PLAYER_JUMP_EN
    frame(1'b0, 1'b0, 1'b0, 1'b1);
    check_all("jump_go");
    frames(16, 1'b0, 1'b0, 1'b0, "rise");
    check("apex_y", int'(yp1), 436);
    frames(16, 1'b0, 1'b0, 1'b0, "fall");
    check("land_y", int'(yp1), 500);
    frame(1'b0, 1'b1, 1'b0, 1'b1);
    check_all("jump2_go");
    frames(8, 1'b0, 1'b1, 1'b0, "rise8");
    async_reset("jump_rst");
    check("jump_rst_y", int'(yp1), 500);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
